// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : CPU load/store bridge to a handshaked word memory, with
//                   sub-word read-modify-write, alignment checks and timeout.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] addr,
  output logic [31:0] wd,
  input  logic [31:0] rd,
  input  logic        state
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4,
    DONE    = 3'd5
  } fsm_t;

  fsm_t          cur;
  logic          seen_busy;
  logic [CW-1:0] tcount;

  logic          req;
  logic          misaligned;
  logic          timed_out;
  logic          wait_done;
  logic [31:0]   shifted;
  logic [31:0]   load_val;
  logic [31:0]   merge_val;

  assign req        = cpu_read | cpu_write;
  assign misaligned = (cpu_size == 2'b11)
                    | ((cpu_size == 2'b01) & cpu_addr[0])
                    | ((cpu_size == 2'b10) & (cpu_addr[1:0] != 2'b00));
  assign timed_out  = (tcount == TO_LAST);
  assign wait_done  = state & seen_busy;

  assign MemRead    = (cur == RD_REQ);
  assign MemWrite   = (cur == WR_REQ);
  assign cpu_stall  = (cur == IDLE) ? req : (cur != DONE);

  // Bring the addressed lane down to bit 0 before extending.
  assign shifted = rd >> {cpu_addr[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (cpu_size)
      2'b00:   load_val = cpu_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = cpu_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    merge_val = rd;
    case (cpu_size)
      2'b00: begin
        case (cpu_addr[1:0])
          2'b00:   merge_val[7:0]   = cpu_wdata[7:0];
          2'b01:   merge_val[15:8]  = cpu_wdata[7:0];
          2'b10:   merge_val[23:16] = cpu_wdata[7:0];
          default: merge_val[31:24] = cpu_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (cpu_addr[1]) merge_val[31:16] = cpu_wdata[15:0];
        else             merge_val[15:0]  = cpu_wdata[15:0];
      end
      default: merge_val = rd;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= IDLE;
      cpu_rdata <= '0;
      cpu_error <= 1'b0;
      addr      <= '0;
      wd        <= '0;
      seen_busy <= 1'b0;
      tcount    <= '0;
    end else begin
      cpu_error <= 1'b0;
      case (cur)
        IDLE: begin
          if (req) begin
            tcount    <= '0;
            seen_busy <= 1'b0;
            if (misaligned) begin
              cur       <= DONE;
              cpu_error <= 1'b1;
              if (cpu_read) cpu_rdata <= '0;
            end else begin
              addr <= {cpu_addr[31:2], 2'b00};
              wd   <= cpu_wdata;
              // Loads and sub-word stores both start with a read.
              if (cpu_read || (cpu_size != 2'b10)) cur <= RD_REQ;
              else                                 cur <= WR_REQ;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          tcount <= tcount + 1'b1;
          if (timed_out) begin
            cur       <= DONE;
            cpu_error <= 1'b1;
            cpu_rdata <= '0;
          end else if (state) begin
            seen_busy <= 1'b0;
            if (cur == RD_REQ) cur <= RD_WAIT;
            else               cur <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          tcount <= tcount + 1'b1;
          if (!state) seen_busy <= 1'b1;
          if (wait_done) begin
            if (cpu_read) begin
              cpu_rdata <= load_val;
              cur       <= DONE;
            end else begin
              wd  <= merge_val;
              cur <= WR_REQ;
            end
          end else if (timed_out) begin
            cur       <= DONE;
            cpu_error <= 1'b1;
            cpu_rdata <= '0;
          end
        end
        WR_WAIT: begin
          tcount <= tcount + 1'b1;
          if (!state) seen_busy <= 1'b1;
          if (wait_done) begin
            cur <= DONE;
          end else if (timed_out) begin
            cur       <= DONE;
            cpu_error <= 1'b1;
            cpu_rdata <= '0;
          end
        end
        default: cur <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : scoreboard bench with a latency-programmable memory.
// Revision           : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_error, MemRead, MemWrite;
  logic [31:0] addr, wd, rd;
  logic        state;

  mem_access_ctrl #(.TIMEOUT(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_size(cpu_size),
    .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_error(cpu_error),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd),
    .rd(rd), .state(state)
  );

  always #5 clk = ~clk;

  // Memory model: accepts a request while free, then stays busy for a
  // programmable number of cycles; writes land when the busy period ends.
  logic [31:0] mem [0:63];
  logic        busy    = 1'b0;
  logic        is_wr   = 1'b0;
  int          cnt     = 0;
  logic [5:0]  lat_idx = '0;
  logic [31:0] lat_wd  = '0;
  logic        hold_busy = 1'b0;
  logic        pl_en     = 1'b0;
  logic [5:0]  pl_idx    = '0;
  logic [31:0] pl_val    = '0;
  int          rd_lat    = 4;
  int          wr_lat    = 8;

  assign state = ~busy & ~hold_busy;
  assign rd    = mem[lat_idx];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    if (!busy) begin
      if (state && MemRead) begin
        busy <= 1'b1; is_wr <= 1'b0; cnt <= rd_lat; lat_idx <= addr[7:2];
      end else if (state && MemWrite) begin
        busy <= 1'b1; is_wr <= 1'b1; cnt <= wr_lat; lat_idx <= addr[7:2];
        lat_wd <= wd;
      end
    end else begin
      if (cnt == 1) begin
        busy <= 1'b0;
        if (is_wr) mem[lat_idx] <= lat_wd;
      end
      cnt <= cnt - 1;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
    int          mr;
    int          mw;
    int          mr_free;
    logic [31:0] wdv;
    logic        to;
    logic        post_err;
    logic        post_stall;
  } obs_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'h0;

  // Caller is positioned just after a falling edge; request is driven at once.
  task automatic run_access(input logic r, input logic w, input logic [1:0] sz,
                            input logic u, input logic [31:0] a,
                            input logic [31:0] wdat, output obs_t o);
    o = '{32'h0, 1'b0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 1'b0};
    cpu_read = r; cpu_write = w; cpu_size = sz; cpu_unsigned = u;
    cpu_addr = a; cpu_wdata = wdat;
    #1;
    for (int i = 0; i < 200; i++) begin
      if (MemRead) o.mr++;
      if (MemRead && state) o.mr_free++;
      if (MemWrite) begin o.mw++; o.wdv = wd; end
      if (!cpu_stall) begin
        o.rdata = cpu_rdata; o.err = cpu_error; o.to = 1'b0;
        break;
      end
      o.stall++;
      @(negedge clk); #1;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(negedge clk); #1;
    o.post_err = cpu_error; o.post_stall = cpu_stall;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({cpu_rdata, addr, wd, cpu_error, MemRead, MemWrite, cpu_stall} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdata=%h addr=%h wd=%h err=%b mr=%b mw=%b stall=%b, want all zero",
               cpu_rdata, addr, wd, cpu_error, MemRead, MemWrite, cpu_stall);
    end
    rst = 1'b0;
    poke(6'd4,  32'h84332211);
    poke(6'd8,  32'h0BADF00D);
    poke(6'd12, 32'h12345678);
  endtask

  task automatic test_word_load();
    obs_t o; exp_t x;
    sb.push_back('{32'h84332211, 1'b0, 1'b1});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, o);
    x = sb.pop_front();
    last_rdata = x.rdata;
    n_checks++;
    if (o.to !== 1'b0) begin n_fail++; $display("FAIL word_load_done: got timeout=1, want DONE"); end
    n_checks++;
    if (o.rdata !== x.rdata) begin n_fail++; $display("FAIL word_load_rdata: got %h want %h", o.rdata, x.rdata); end
    n_checks++;
    if (o.err !== x.err) begin n_fail++; $display("FAIL word_load_err: got %b want %b", o.err, x.err); end
    n_checks++;
    if (o.mr != 1) begin n_fail++; $display("FAIL word_load_memread_cycles: got %0d want 1", o.mr); end
    n_checks++;
    if (o.post_stall !== 1'b0 || o.post_err !== 1'b0) begin
      n_fail++; $display("FAIL word_load_after_done: stall=%b err=%b want 0 0", o.post_stall, o.post_err);
    end
  endtask

  task automatic test_back_to_back_loads();
    logic [31:0] ta [6] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11, 32'h12};
    logic [1:0]  ts [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        tu [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] te [6] = '{32'hFFFFFF84, 32'h00000084, 32'hFFFF8433,
                            32'h00002211, 32'h00000022, 32'h00000033};
    obs_t o; exp_t x;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{te[i], 1'b0, 1'b1});
      run_access(1'b1, 1'b0, ts[i], tu[i], ta[i], 32'h0, o);
      x = sb.pop_front();
      last_rdata = x.rdata;
      n_checks++;
      if (o.to !== 1'b0 || o.rdata !== x.rdata || o.err !== x.err) begin
        n_fail++;
        $display("FAIL load_%0d: timeout=%b rdata=%h err=%b, want timeout=0 rdata=%h err=%b",
                 i, o.to, o.rdata, o.err, x.rdata, x.err);
      end
    end
  endtask

  task automatic test_rmw_store();
    logic [31:0] ta [3] = '{32'h11, 32'h12, 32'h30};
    logic [1:0]  ts [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] tw [3] = '{32'h123456AB, 32'hFFFFBEEF, 32'hCAFEF00D};
    logic [31:0] tm [3] = '{32'h8433AB11, 32'hBEEFAB11, 32'hCAFEF00D};
    int          tr [3] = '{1, 1, 0};
    obs_t o; exp_t x;
    wr_lat = 8;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{last_rdata, 1'b0, 1'b1});
      run_access(1'b0, 1'b1, ts[i], 1'b0, ta[i], tw[i], o);
      x = sb.pop_front();
      n_checks++;
      if (o.to !== 1'b0 || o.err !== x.err || o.rdata !== x.rdata) begin
        n_fail++;
        $display("FAIL store_%0d_status: timeout=%b err=%b rdata=%h, want 0 %b %h",
                 i, o.to, o.err, o.rdata, x.err, x.rdata);
      end
      n_checks++;
      if (o.mr != tr[i] || o.mw != 1) begin
        n_fail++;
        $display("FAIL store_%0d_requests: reads=%0d writes=%0d, want %0d 1", i, o.mr, o.mw, tr[i]);
      end
      n_checks++;
      if (o.wdv !== tm[i]) begin n_fail++; $display("FAIL store_%0d_wd: got %h want %h", i, o.wdv, tm[i]); end
      n_checks++;
      if (mem[ta[i][7:2]] !== tm[i]) begin
        n_fail++; $display("FAIL store_%0d_mem: got %h want %h", i, mem[ta[i][7:2]], tm[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        tr [3] = '{1'b1, 1'b0, 1'b1};
    logic [1:0]  ts [3] = '{2'b01, 2'b10, 2'b11};
    logic [31:0] ta [3] = '{32'h13, 32'h12, 32'h10};
    obs_t o; exp_t x;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 1'b1, 1'b0});
      run_access(tr[i], ~tr[i], ts[i], 1'b0, ta[i], 32'hA5A5A5A5, o);
      x = sb.pop_front();
      n_checks++;
      if (o.to !== 1'b0 || o.err !== x.err || o.stall != 1) begin
        n_fail++;
        $display("FAIL misaligned_%0d: timeout=%b err=%b stall_cycles=%0d, want 0 1 1", i, o.to, o.err, o.stall);
      end
      n_checks++;
      if (o.mr != 0 || o.mw != 0 || o.post_err !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned_%0d_side: reads=%0d writes=%0d err_next=%b, want 0 0 0", i, o.mr, o.mw, o.post_err);
      end
    end
    n_checks++;
    if (mem[4] !== 32'hBEEFAB11) begin n_fail++; $display("FAIL misaligned_mem: got %h want beefab11", mem[4]); end
  endtask

  task automatic test_priority();
    obs_t o; exp_t x;
    sb.push_back('{32'h0BADF00D, 1'b0, 1'b1});
    run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h55555555, o);
    x = sb.pop_front();
    last_rdata = x.rdata;
    n_checks++;
    if (o.to !== 1'b0 || o.rdata !== x.rdata || o.mw != 0 || mem[8] !== 32'h0BADF00D) begin
      n_fail++;
      $display("FAIL read_priority: timeout=%b rdata=%h writes=%0d mem=%h, want 0 %h 0 0badf00d",
               o.to, o.rdata, o.mw, mem[8], x.rdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t x;
    hold_busy = 1'b1;
    sb.push_back('{32'h0, 1'b1, 1'b1});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, o);
    x = sb.pop_front();
    hold_busy = 1'b0;
    n_checks++;
    if (o.to !== 1'b0 || o.err !== x.err || o.rdata !== x.rdata) begin
      n_fail++;
      $display("FAIL timeout_result: timeout=%b err=%b rdata=%h, want 0 1 %h", o.to, o.err, o.rdata, x.rdata);
    end
    n_checks++;
    if (o.mr != 32 || o.stall != 33) begin
      n_fail++;
      $display("FAIL timeout_cycles: memread=%0d stall=%0d, want 32 33", o.mr, o.stall);
    end
    n_checks++;
    if (o.post_err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_pulse: got %b want 0", o.post_err); end
  endtask

  task automatic test_reset_mid_write();
    obs_t o; exp_t x;
    logic seen;
    seen = 1'b0;
    wr_lat = 8;
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_size = 2'b10; cpu_unsigned = 1'b0;
    cpu_addr = 32'h30; cpu_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (MemWrite) begin seen = 1'b1; break; end
    end
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (seen !== 1'b1 || cpu_stall !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_setup: write_seen=%b stall=%b, want 1 1", seen, cpu_stall);
    end
    rst = 1'b1; cpu_write = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if ({cpu_rdata, addr, wd, cpu_error, MemRead, MemWrite, cpu_stall} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: rdata=%h addr=%h wd=%h err=%b mr=%b mw=%b stall=%b, want all zero",
               cpu_rdata, addr, wd, cpu_error, MemRead, MemWrite, cpu_stall);
    end
    rst = 1'b0;
    sb.push_back('{32'h0BADF00D, 1'b0, 1'b1});
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, o);
    x = sb.pop_front();
    n_checks++;
    if (o.to !== 1'b0 || o.rdata !== x.rdata || o.err !== x.err) begin
      n_fail++;
      $display("FAIL reset_mid_load: timeout=%b rdata=%h err=%b, want 0 %h %b", o.to, o.rdata, o.err, x.rdata, x.err);
    end
    n_checks++;
    if (o.mr < 2 || o.mr_free != 1) begin
      n_fail++;
      $display("FAIL reset_mid_memread: cycles=%0d accepted=%0d, want >=2 and 1", o.mr, o.mr_free);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_size = 2'b00;
    cpu_unsigned = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    test_reset();
    test_word_load();
    test_back_to_back_loads();
    test_rmw_store();
    test_misaligned();
    test_priority();
    test_timeout();
    test_reset_mid_write();
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left, want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
